// File: rtl/otn_frame_ack_gen.sv
// rtl/otn_frame_ack_gen.sv - OTN far-end frame checker with serial BIP-8 ACK return
//
// Consumes the serial OTN frame stream, hunts for the frame alignment word,
// folds the payload into a BIP-8, compares it against the trailer byte and,
// when ARQ is enabled, returns a start/ack/stop symbol sequence on the ACK line.
//
// Ports:
//   i_clk            clock
//   i_rst            asynchronous active-high reset
//   i_otn_rx_data    serial frame bit, MSB first
//   i_otn_rx_valid   i_otn_rx_data is accepted this cycle
//   i_arq_en         1 = send ACK sequence after each checked frame
//   o_otn_tx_ack     serial ACK line, idle high
//   o_frame_good     one-cycle pulse, frame passed BIP-8
//   o_frame_bad      one-cycle pulse, frame failed BIP-8
//   o_frame_count    frames checked, saturating
//   o_err_count      bad frames, saturating
//   o_busy           high in every state except HUNT

module otn_frame_ack_gen #(
    parameter logic [47:0] FAS_PATTERN  = 48'hF6F6F6282828,
    parameter int          PAYLOAD_BITS = 33256,
    parameter int          BIT_CYCLES   = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_otn_rx_data,
    input  logic        i_otn_rx_valid,
    input  logic        i_arq_en,
    output logic        o_otn_tx_ack,
    output logic        o_frame_good,
    output logic        o_frame_bad,
    output logic [15:0] o_frame_count,
    output logic [15:0] o_err_count,
    output logic        o_busy
);

    // The bit counter also walks the 8 trailer bits, so it is never narrower than 3 bits.
    localparam int CNT_RAW = $clog2(PAYLOAD_BITS + 1);
    localparam int CNT_W   = (CNT_RAW < 3) ? 3 : CNT_RAW;
    localparam int SYM_W   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAYLOAD_BITS - 1);
    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        HUNT,
        PAYLOAD,
        TRAILER,
        CHECK,
        ACK_START,
        ACK_BIT,
        ACK_STOP
    } state_t;

    state_t           state_q;
    logic [47:0]      fas_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       bip_q;
    logic [7:0]       trl_q;
    logic [SYM_W-1:0] sym_q;
    logic             good_q;
    logic             ack_q;
    logic             frame_good_q;
    logic             frame_bad_q;
    logic [15:0]      frame_count_q;
    logic [15:0]      err_count_q;
    logic             busy_q;

    // Next-state helpers for the accepted-bit datapaths.
    logic [47:0]      fas_d;
    logic [7:0]       bip_d;
    logic [7:0]       trl_d;
    logic [15:0]      frame_count_d;
    logic [15:0]      err_count_d;
    logic             frame_ok;
    logic             sym_done;

    always_comb begin
        fas_d = {fas_q[46:0], i_otn_rx_data};
        trl_d = {trl_q[6:0], i_otn_rx_data};

        // Payload bytes fold MSB-aligned: bit 0 of each byte lands on BIP[7].
        bip_d = bip_q;
        bip_d[3'd7 - cnt_q[2:0]] = bip_q[3'd7 - cnt_q[2:0]] ^ i_otn_rx_data;

        frame_count_d = (frame_count_q == 16'hFFFF) ? frame_count_q : frame_count_q + 16'd1;
        err_count_d   = (err_count_q   == 16'hFFFF) ? err_count_q   : err_count_q   + 16'd1;

        frame_ok = (trl_q == bip_q);
        sym_done = (sym_q == SYM_LAST);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= HUNT;
            fas_q         <= 48'd0;
            cnt_q         <= '0;
            bip_q         <= 8'd0;
            trl_q         <= 8'd0;
            sym_q         <= '0;
            good_q        <= 1'b0;
            ack_q         <= 1'b1;
            frame_good_q  <= 1'b0;
            frame_bad_q   <= 1'b0;
            frame_count_q <= 16'd0;
            err_count_q   <= 16'd0;
            busy_q        <= 1'b0;
        end else begin
            frame_good_q <= 1'b0;
            frame_bad_q  <= 1'b0;

            case (state_q)
                HUNT: begin
                    if (i_otn_rx_valid) begin
                        fas_q <= fas_d;
                        if (fas_d == FAS_PATTERN) begin
                            state_q <= PAYLOAD;
                            cnt_q   <= '0;
                            bip_q   <= 8'd0;
                            busy_q  <= 1'b1;
                        end
                    end
                end

                PAYLOAD: begin
                    if (i_otn_rx_valid) begin
                        bip_q <= bip_d;
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= TRAILER;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end

                TRAILER: begin
                    if (i_otn_rx_valid) begin
                        trl_q <= trl_d;
                        if (cnt_q[2:0] == 3'd7) begin
                            cnt_q   <= '0;
                            state_q <= CHECK;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end

                CHECK: begin
                    // Input is ignored here; the verdict is latched for the ACK symbol.
                    good_q        <= frame_ok;
                    frame_good_q  <= frame_ok;
                    frame_bad_q   <= ~frame_ok;
                    frame_count_q <= frame_count_d;
                    if (!frame_ok) begin
                        err_count_q <= err_count_d;
                    end
                    if (i_arq_en) begin
                        state_q <= ACK_START;
                        ack_q   <= 1'b0;
                        sym_q   <= '0;
                    end else begin
                        state_q <= HUNT;
                        busy_q  <= 1'b0;
                        fas_q   <= 48'd0;
                    end
                end

                ACK_START: begin
                    if (sym_done) begin
                        sym_q   <= '0;
                        state_q <= ACK_BIT;
                        ack_q   <= good_q;
                    end else begin
                        sym_q <= sym_q + SYM_W'(1);
                    end
                end

                ACK_BIT: begin
                    if (sym_done) begin
                        sym_q   <= '0;
                        state_q <= ACK_STOP;
                        ack_q   <= 1'b0;
                    end else begin
                        sym_q <= sym_q + SYM_W'(1);
                    end
                end

                ACK_STOP: begin
                    if (sym_done) begin
                        sym_q   <= '0;
                        state_q <= HUNT;
                        ack_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        // Realignment must see a full fresh FAS word.
                        fas_q   <= 48'd0;
                    end else begin
                        sym_q <= sym_q + SYM_W'(1);
                    end
                end

                default: begin
                    state_q <= HUNT;
                    ack_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    fas_q   <= 48'd0;
                end
            endcase
        end
    end

    assign o_otn_tx_ack  = ack_q;
    assign o_frame_good  = frame_good_q;
    assign o_frame_bad   = frame_bad_q;
    assign o_frame_count = frame_count_q;
    assign o_err_count   = err_count_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_otn_frame_ack_gen.sv
// tb/tb_otn_frame_ack_gen.sv - directed self-checking bench for otn_frame_ack_gen

module tb_otn_frame_ack_gen;

    localparam logic [47:0] FAS = 48'hF6F6F6282828;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_data;
    logic        rx_valid;
    logic        arq_en;

    logic        ack1, good1, bad1, busy1;
    logic [15:0] fcnt1, ecnt1;
    logic        ack4, good4, bad4, busy4;
    logic [15:0] fcnt4, ecnt4;

    int tests = 0;
    int fails = 0;

    logic watch_ack = 1'b0;
    logic ack_dropped = 1'b0;

    always #5 clk = ~clk;

    otn_frame_ack_gen #(.FAS_PATTERN(FAS), .PAYLOAD_BITS(16), .BIT_CYCLES(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_otn_rx_data(rx_data), .i_otn_rx_valid(rx_valid),
        .i_arq_en(arq_en), .o_otn_tx_ack(ack1), .o_frame_good(good1), .o_frame_bad(bad1),
        .o_frame_count(fcnt1), .o_err_count(ecnt1), .o_busy(busy1)
    );

    otn_frame_ack_gen #(.FAS_PATTERN(FAS), .PAYLOAD_BITS(16), .BIT_CYCLES(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_otn_rx_data(rx_data), .i_otn_rx_valid(rx_valid),
        .i_arq_en(arq_en), .o_otn_tx_ack(ack4), .o_frame_good(good4), .o_frame_bad(bad4),
        .o_frame_count(fcnt4), .o_err_count(ecnt4), .o_busy(busy4)
    );

    always @(negedge clk) begin
        if (watch_ack && ack1 !== 1'b1) ack_dropped = 1'b1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit gap);
        if (gap) begin
            rx_valid = 1'b0;
            rx_data  = ~b;
            tick();
        end
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] trl, input bit gap);
        logic [47:0] f = FAS;
        logic [15:0] p = 16'hA55A;
        logic [7:0]  t;
        t = trl;
        for (int i = 47; i >= 0; i--) send_bit(f[i], gap);
        for (int i = 15; i >= 0; i--) send_bit(p[i], gap);
        for (int i = 7; i >= 0; i--)  send_bit(t[i], gap);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic seen_busy;
        rst = 1'b1; rx_data = 1'b0; rx_valid = 1'b0; arq_en = 1'b1;
        tick(); tick();

        // Reset state
        chk("rst_ack",   {15'd0, ack1},  16'd1);
        chk("rst_good",  {15'd0, good1}, 16'd0);
        chk("rst_bad",   {15'd0, bad1},  16'd0);
        chk("rst_busy",  {15'd0, busy1}, 16'd0);
        chk("rst_fcnt",  fcnt1, 16'd0);
        chk("rst_ecnt",  ecnt1, 16'd0);
        rst = 1'b0;
        tick();

        // 1: good frame, BIP = A5^5A = FF
        send_frame(8'hFF, 1'b0);
        chk("t1_busy_check", {15'd0, busy1}, 16'd1);
        tick();
        chk("t1_good",  {15'd0, good1}, 16'd1);
        chk("t1_bad",   {15'd0, bad1},  16'd0);
        chk("t1_fcnt",  fcnt1, 16'd1);
        chk("t1_ack0",  {15'd0, ack1},  16'd0);
        tick();
        chk("t1_ack1",  {15'd0, ack1},  16'd1);
        chk("t1_good_end", {15'd0, good1}, 16'd0);
        tick();
        chk("t1_ack2",  {15'd0, ack1},  16'd0);
        tick();
        chk("t1_ack3",  {15'd0, ack1},  16'd1);
        chk("t1_busy",  {15'd0, busy1}, 16'd0);

        // 2: bad frame
        send_frame(8'hFE, 1'b0);
        tick();
        chk("t2_bad",   {15'd0, bad1},  16'd1);
        chk("t2_good",  {15'd0, good1}, 16'd0);
        chk("t2_ecnt",  ecnt1, 16'd1);
        chk("t2_fcnt",  fcnt1, 16'd2);
        chk("t2_ack0",  {15'd0, ack1},  16'd0);
        tick();
        chk("t2_ack1",  {15'd0, ack1},  16'd0);
        tick();
        chk("t2_ack2",  {15'd0, ack1},  16'd0);
        tick();
        chk("t2_ack3",  {15'd0, ack1},  16'd1);

        // 3: false FAS then a real frame
        pulse_reset();
        seen_busy = 1'b0;
        for (int i = 47; i >= 1; i--) begin
            send_bit(FAS[i], 1'b0);
            seen_busy = seen_busy | busy1;
        end
        send_bit(~FAS[0], 1'b0);
        seen_busy = seen_busy | busy1;
        chk("t3_hunt_partial", {15'd0, seen_busy}, 16'd0);
        send_frame(8'hFF, 1'b0);
        tick();
        chk("t3_good",  {15'd0, good1}, 16'd1);
        chk("t3_fcnt",  fcnt1, 16'd1);
        tick(); tick(); tick();
        chk("t3_fcnt_end", fcnt1, 16'd1);

        // 4: ARQ disabled
        arq_en = 1'b0;
        ack_dropped = 1'b0;
        watch_ack = 1'b1;
        send_frame(8'hFF, 1'b0);
        tick();
        chk("t4_good",  {15'd0, good1}, 16'd1);
        chk("t4_busy",  {15'd0, busy1}, 16'd0);
        chk("t4_fcnt",  fcnt1, 16'd2);
        tick(); tick(); tick();
        watch_ack = 1'b0;
        chk("t4_ack_high", {15'd0, ack_dropped}, 16'd0);
        arq_en = 1'b1;

        // 5: valid gaps every other cycle
        pulse_reset();
        send_frame(8'hFF, 1'b1);
        tick();
        chk("t5_good",  {15'd0, good1}, 16'd1);
        chk("t5_bad",   {15'd0, bad1},  16'd0);
        chk("t5_fcnt",  fcnt1, 16'd1);
        chk("t5_ack0",  {15'd0, ack1},  16'd0);
        tick();
        chk("t5_ack1",  {15'd0, ack1},  16'd1);
        tick();
        chk("t5_ack2",  {15'd0, ack1},  16'd0);
        tick();
        chk("t5_ack3",  {15'd0, ack1},  16'd1);
        chk("t5_busy",  {15'd0, busy1}, 16'd0);

        // 6: reset during ACK_BIT with BIT_CYCLES = 4
        pulse_reset();
        send_frame(8'hFE, 1'b0);
        tick();
        chk("t6_bad",   {15'd0, bad4},  16'd1);
        chk("t6_ecnt",  ecnt4, 16'd1);
        chk("t6_start0", {15'd0, ack4}, 16'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("t6_start_hold", {15'd0, ack4}, 16'd0);
        end
        tick();
        chk("t6_bit_ack",  {15'd0, ack4},  16'd0);
        chk("t6_bit_busy", {15'd0, busy4}, 16'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_ack",  {15'd0, ack4},  16'd1);
        chk("t6_rst_busy", {15'd0, busy4}, 16'd0);
        chk("t6_rst_fcnt", fcnt4, 16'd0);
        chk("t6_rst_ecnt", ecnt4, 16'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_post_ack", {15'd0, ack4}, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/otn_frame_ack_gen.md
Name: otn_frame_ack_gen

Overview:
- Far-end receiver stage that consumes the serial OTN frame stream produced by the sender's transmit/ARQ stage.
- Hunts for the FAS pattern, accumulates BIP-8 over the payload, and compares it against the received trailer byte.
- When ARQ is enabled, returns the result on the serial ACK line in the sender's ACK format: idle-high, low start bit, ACK bit ('1' good, '0' bad), low stop bit.

Parameters:
- FAS_PATTERN, 48'hF6F6F6282828, frame alignment word, received MSB first.
- PAYLOAD_BITS, 33256, payload bits between FAS and trailer (4157 bytes; the whole frame is 4164 bytes).
- BIT_CYCLES, 1, clock cycles each ACK symbol is held; must be ≥1.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_otn_rx_data  in  1  serial frame bit
- i_otn_rx_valid  in  1  i_otn_rx_data is accepted on this cycle
- i_arq_en  in  1  switch input; 1 = send ACK sequence after each frame
- o_otn_tx_ack  out  1  serial ACK line to the sender, idle high
- o_frame_good  out  1  one-cycle pulse: frame passed BIP-8
- o_frame_bad  out  1  one-cycle pulse: frame failed BIP-8
- o_frame_count  out  16  frames checked, saturates at 16'hFFFF
- o_err_count  out  16  bad frames, saturates at 16'hFFFF
- o_busy  out  1  high in every state except HUNT

Behaviour:
- Reset (async, immediate):
  - state = HUNT; o_otn_tx_ack = 1.
  - o_frame_good, o_frame_bad, o_busy = 0.
  - Both counters, the FAS shift register, BIP accumulator, bit counter and trailer register are cleared.
  - Reset mid-frame or mid-ACK drops the frame with no pulse and forces the ACK line high.
- All outputs are registered. Input bits are consumed only when i_otn_rx_valid = 1; valid-low cycles freeze the counters and the shift register.
- HUNT:
  - On each accepted bit, shift it into the LSB of the 48-bit register.
  - If the post-shift value equals FAS_PATTERN, go to PAYLOAD on the next cycle with bit counter = 0 and BIP = 0.
- PAYLOAD:
  - On each accepted bit, BIP[7 - (cnt mod 8)] ^= bit, so bytes fold MSB-aligned; then cnt++.
  - On the accepted bit where cnt == PAYLOAD_BITS-1, go to TRAILER with cnt = 0.
- TRAILER:
  - Shift 8 accepted bits MSB first into the trailer register.
  - After the 8th bit, go to CHECK.
- CHECK (exactly one cycle, input ignored):
  - good = (trailer == BIP).
  - Pulse o_frame_good or o_frame_bad in the cycle after CHECK.
  - Increment o_frame_count; increment o_err_count if bad. Both saturate.
  - Next state is ACK_START if i_arq_en = 1 (sampled in CHECK); otherwise HUNT.
- ACK_START: o_otn_tx_ack = 0 for BIT_CYCLES cycles.
- ACK_BIT: o_otn_tx_ack = good for BIT_CYCLES cycles.
- ACK_STOP: o_otn_tx_ack = 0 for BIT_CYCLES cycles.
- After ACK_STOP: go to HUNT, o_otn_tx_ack returns to 1.
- Input bits arriving during CHECK or any ACK_* state are discarded.
- On entry to HUNT the FAS shift register is cleared, so realignment needs a full 48 fresh bits.
- The ACK line never shows a low for fewer than BIT_CYCLES cycles.
- A FAS match inside a payload is ignored; there is no mid-frame resync.
- i_arq_en changes outside CHECK have no effect on the frame in progress.

Test Plan:
1. Good frame (PAYLOAD_BITS=16, BIT_CYCLES=1, arq_en=1): FAS, payload 0xA5 0x5A, trailer 0xFF. Expect:
   - o_frame_good pulse and o_frame_count = 1;
   - ACK line 0,1,0 on three consecutive cycles, then 1;
   - o_busy low afterwards.
2. Bad frame: same payload, trailer 0xFE. Expect:
   - o_frame_bad pulse and o_err_count = 1;
   - ACK line 0,0,0, then 1.
3. False FAS: first 47 FAS bits followed by the wrong bit, then a full FAS and a good frame. Expect:
   - state stays HUNT through the partial word;
   - exactly one frame checked (count = 1).
4. arq_en=0 good frame. Expect:
   - o_frame_good pulse;
   - o_otn_tx_ack stays 1 throughout;
   - o_busy drops the cycle after CHECK.
5. Valid gaps: the good frame of test 1 with i_otn_rx_valid toggling 1,0 every cycle. Expect the same result as test 1, with BIP 0xFF.
6. Reset mid-ACK: assert i_rst during ACK_BIT of test 2 (BIT_CYCLES=4). Expect:
   - o_otn_tx_ack = 1 immediately;
   - counters = 0 and state = HUNT.
